// File: rtl/flash_cmd_model.sv
// Behavioural NOR-flash model: AMD-style unlock/program command set over an async SRAM-like bus.
// Sector and chip erase are compiled in only when FLASH_MODEL_ERASE_EN is defined.
module flash_cmd_model #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned PROG_CYCLES  = 4,
  parameter int unsigned ERASE_CYCLES = 64,
  parameter int unsigned SECTOR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] flash_address,
  input  logic              flash_ce_n,
  input  logic              flash_oe_n,
  input  logic              flash_we_n,
  inout  wire  [DATA_W-1:0] flash_data,
  output logic              flash_ready
);

  localparam int unsigned Words  = 2 ** ADDR_W;
  localparam int unsigned CntMax = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  if (DATA_W < 8 || ADDR_W < 11 || RD_LAT < 1 || PROG_CYCLES < 1 || ERASE_CYCLES < 1 ||
      SECTOR_W >= ADDR_W) begin : g_param_check
    $error("flash_cmd_model: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    StRead,
    StUnlk1,
    StUnlk2,
    StProgSetup,
    StBusyProg
`ifdef FLASH_MODEL_ERASE_EN
    ,
    StEraseSetup,
    StBusyErase
`endif
  } state_e;

  logic [DATA_W-1:0] mem [Words];

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [DATA_W-1:0] prog_data_q, prog_data_d;
  logic [ADDR_W-1:0] rd_pipe_q [RD_LAT];
  logic              we_idle_q;
  logic              toggle_q;
  logic              wr_evt;
  logic              busy;
  logic              drive_en;
  logic              do_prog;
  logic [10:0]       cmd_addr;
  logic [7:0]        cmd_data;
  logic [DATA_W-1:0] dout;

`ifdef FLASH_MODEL_ERASE_EN
  localparam int unsigned SectorWords = 2 ** SECTOR_W;

  logic [ADDR_W-SECTOR_W-1:0] sector_q, sector_d;
  logic                       chip_q, chip_d;
  logic                       do_erase;

  assign busy = (state_q == StBusyProg) || (state_q == StBusyErase);
`else
  assign busy = (state_q == StBusyProg);
`endif

  assign flash_ready = ~busy;
  assign drive_en    = ~flash_ce_n & ~flash_oe_n & flash_we_n;
  assign flash_data  = drive_en ? dout : {DATA_W{1'bz}};

  // One write per we_n pulse: only the first low edge after an idle cycle counts.
  assign wr_evt   = ~flash_ce_n & ~flash_we_n & we_idle_q;
  assign cmd_addr = flash_address[10:0];
  assign cmd_data = flash_data[7:0];

  always_comb begin
    dout = mem[rd_pipe_q[RD_LAT-1]];
    if (busy) begin
      dout    = '0;
      dout[6] = toggle_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    do_prog     = 1'b0;
`ifdef FLASH_MODEL_ERASE_EN
    sector_d    = sector_q;
    chip_d      = chip_q;
    do_erase    = 1'b0;
`endif
    case (state_q)
      StRead: begin
        if (wr_evt && cmd_addr == 11'h555 && cmd_data == 8'hAA) state_d = StUnlk1;
      end
      StUnlk1: begin
        if (wr_evt) begin
          state_d = (cmd_addr == 11'h2AA && cmd_data == 8'h55) ? StUnlk2 : StRead;
        end
      end
      StUnlk2: begin
        if (wr_evt) begin
          state_d = StRead;
          if (cmd_addr == 11'h555 && cmd_data == 8'hA0) state_d = StProgSetup;
`ifdef FLASH_MODEL_ERASE_EN
          if (cmd_addr == 11'h555 && cmd_data == 8'h80) state_d = StEraseSetup;
`endif
        end
      end
      StProgSetup: begin
        if (wr_evt) begin
          prog_addr_d = flash_address;
          prog_data_d = flash_data;
          cnt_d       = CntW'(PROG_CYCLES);
          state_d     = StBusyProg;
        end
      end
      StBusyProg: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = '0;
          do_prog = 1'b1;
          state_d = StRead;
        end
      end
`ifdef FLASH_MODEL_ERASE_EN
      StEraseSetup: begin
        if (wr_evt) begin
          state_d = StRead;
          if (cmd_data == 8'h30 || cmd_data == 8'h10) begin
            sector_d = flash_address[ADDR_W-1:SECTOR_W];
            chip_d   = (cmd_data == 8'h10);
            cnt_d    = CntW'(ERASE_CYCLES);
            state_d  = StBusyErase;
          end
        end
      end
      StBusyErase: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntW'(1)) begin
          cnt_d    = '0;
          do_erase = 1'b1;
          state_d  = StRead;
        end
      end
`endif
      default: state_d = StRead;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRead;
      cnt_q       <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      we_idle_q   <= 1'b1;
      toggle_q    <= 1'b0;
`ifdef FLASH_MODEL_ERASE_EN
      sector_q    <= '0;
      chip_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      we_idle_q   <= flash_ce_n | flash_we_n;
      if (busy && drive_en) toggle_q <= ~toggle_q;
`ifdef FLASH_MODEL_ERASE_EN
      sector_q    <= sector_d;
      chip_q      <= chip_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LAT); i++) rd_pipe_q[i] <= '0;
    end else begin
      rd_pipe_q[0] <= flash_address;
      for (int i = 1; i < int'(RD_LAT); i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  // Array is deliberately outside the reset domain: an aborted operation leaves it untouched.
  always_ff @(posedge clk) begin
    if (do_prog) mem[prog_addr_q] <= mem[prog_addr_q] & prog_data_q;
`ifdef FLASH_MODEL_ERASE_EN
    if (do_erase) begin
      if (chip_q) begin
        for (int unsigned i = 0; i < Words; i++) mem[ADDR_W'(i)] <= '1;
      end else begin
        for (int unsigned j = 0; j < SectorWords; j++) mem[{sector_q, SECTOR_W'(j)}] <= '1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_flash_cmd_model.sv
// Self-checking bench for flash_cmd_model: array-level reference model plus directed and
// $urandom-driven command sequences.
module tb_flash_cmd_model;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 15;
  localparam int RD_LAT       = 2;
  localparam int PROG_CYCLES  = 4;
  localparam int ERASE_CYCLES = 64;
  localparam int SECTOR_W     = 10;
  localparam int Words        = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] addr;
  logic              ce_n, oe_n, we_n;
  logic [DATA_W-1:0] tb_dq;
  logic              tb_drv;
  logic              flash_ready;
  tri1  [DATA_W-1:0] flash_data;

  logic [DATA_W-1:0] model [Words];
  int checks = 0;
  int errors = 0;

  assign flash_data = tb_drv ? tb_dq : {DATA_W{1'bz}};

  always #5 clk = ~clk;

  flash_cmd_model #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .RD_LAT      (RD_LAT),
    .PROG_CYCLES (PROG_CYCLES),
    .ERASE_CYCLES(ERASE_CYCLES),
    .SECTOR_W    (SECTOR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flash_address(addr),
    .flash_ce_n   (ce_n),
    .flash_oe_n   (oe_n),
    .flash_we_n   (we_n),
    .flash_data   (flash_data),
    .flash_ready  (flash_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    model[a] = v;
    dut.mem[a] <= v;
  endtask

  // One idle cycle, then a one-cycle we_n pulse; returns just after the registering edge.
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; tb_drv = 1'b0;
    cyc();
    addr = a; tb_dq = d; tb_drv = 1'b1; ce_n = 1'b0; we_n = 1'b0;
    cyc();
    ce_n = 1'b1; we_n = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic unlock();
    wr(15'h0555, 16'h00AA);
    wr(15'h02AA, 16'h0055);
  endtask

  task automatic read_chk(input logic [ADDR_W-1:0] a, input string tag);
    addr = a; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; tb_drv = 1'b0;
    repeat (RD_LAT) cyc();
    #1;
    chk(tag, flash_data, model[a]);
  endtask

  // Reads status while busy: only DQ6 may be set and it must alternate every cycle.
  task automatic busy_watch(input int exp_n, input string tag);
    int n;
    logic prev, want;
    logic [DATA_W-1:0] rest;
    n = 0; prev = 1'b0;
    addr = '0; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; tb_drv = 1'b0;
    #1;
    while (flash_ready === 1'b0 && n < 400) begin
      rest = flash_data & 16'hFFBF;
      chk({tag, "_status"}, rest, 16'h0000);
      if (n > 0) begin
        want = ~prev;
        chk({tag, "_dq6"}, flash_data[6], want);
      end
      prev = flash_data[6];
      n++;
      cyc();
      #1;
    end
    chk({tag, "_busy_len"}, n, exp_n);
    ce_n = 1'b1; oe_n = 1'b1;
  endtask

  task automatic prog(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input string tag);
    unlock();
    wr(15'h0555, 16'h00A0);
    wr(a, d);
    busy_watch(PROG_CYCLES, tag);
    model[a] = model[a] & d;
    read_chk(a, {tag, "_rd"});
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic hz;

    rst_n = 1'b0; addr = '0; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; tb_drv = 1'b0; tb_dq = '0;
    for (int i = 0; i < Words; i++) poke(ADDR_W'(i), DATA_W'($urandom));
    poke(15'h0100, 16'h1234);
    poke(15'h00AB, 16'h5A5A);
    #2;
    chk("reset_ready", flash_ready, 1'b1);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Read latency: previous word persists for RD_LAT-1 edges after the address changes.
    addr = 15'h00AB; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    repeat (RD_LAT) cyc();
    #1 chk("lat_prev", flash_data, 16'h5A5A);
    addr = 15'h0100;
    repeat (RD_LAT - 1) cyc();
    #1 chk("lat_early", flash_data, 16'h5A5A);
    cyc();
    #1 chk("lat_data", flash_data, 16'h1234);

    oe_n = 1'b1;
    #1 hz = (flash_data === 16'hFFFF) || (flash_data === 16'hzzzz);
    chk("hiz_oe_high", hz, 1'b1);
    ce_n = 1'b1; oe_n = 1'b0;
    #1 hz = (flash_data === 16'hFFFF) || (flash_data === 16'hzzzz);
    chk("hiz_ce_high", hz, 1'b1);
    ce_n = 1'b0; we_n = 1'b0;
    #1 hz = (flash_data === 16'hFFFF) || (flash_data === 16'hzzzz);
    chk("hiz_oe_we_low", hz, 1'b1);
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    cyc();

    poke(15'h0100, 16'hFFFF);
    prog(15'h0100, 16'h0F0F, "prog_0f0f");
    prog(15'h0100, 16'h00F0, "prog_and");

    for (int k = 0; k < 6; k++) begin
      a = ADDR_W'($urandom);
      d = DATA_W'($urandom);
      prog(a, d, "prog_rnd");
    end

    // Sector erase of 0x0400-0x07FF.
    unlock();
    wr(15'h0555, 16'h0080);
    wr(15'h0400, 16'h0030);
`ifdef FLASH_MODEL_ERASE_EN
    busy_watch(ERASE_CYCLES, "erase_sec");
    for (int i = 16'h0400; i < 16'h0800; i++) model[i] = '1;
`else
    busy_watch(0, "erase_absent");
`endif
    read_chk(15'h0400, "erase_lo");
    read_chk(15'h07FF, "erase_hi");
    read_chk(ADDR_W'(16'h0400 + $urandom_range(0, 1023)), "erase_mid");
    read_chk(15'h03FF, "erase_below");
    read_chk(15'h0800, "erase_above");
    read_chk(15'h0100, "erase_keep");

`ifdef FLASH_MODEL_ERASE_EN
    unlock();
    wr(15'h0555, 16'h0080);
    wr(15'h0000, 16'h0010);
    busy_watch(ERASE_CYCLES, "erase_chip");
    for (int i = 0; i < Words; i++) model[i] = '1;
    for (int k = 0; k < 3; k++) read_chk(ADDR_W'($urandom), "chip_rd");
`endif

    // Reset in the second busy cycle aborts the program.
    poke(15'h1234, 16'hA5C3);
    unlock();
    wr(15'h0555, 16'h00A0);
    wr(15'h1234, 16'h0000);
    cyc();
    rst_n = 1'b0;
    #1 chk("abort_ready", flash_ready, 1'b1);
    cyc();
    rst_n = 1'b1;
    cyc();
    read_chk(15'h1234, "abort_keep");
    prog(15'h1234, DATA_W'($urandom), "after_abort");

    // 555/AA then 2AA/F0 falls back to READ: the rest of the sequence must not program.
    poke(15'h2222, 16'hFFFF);
    wr(15'h0555, 16'h00AA);
    wr(15'h02AA, 16'h00F0);
    wr(15'h02AA, 16'h0055);
    wr(15'h0555, 16'h00A0);
    wr(15'h2222, 16'h0000);
    busy_watch(0, "f0_abort");
    read_chk(15'h2222, "f0_keep");

    // Writes during busy, including F0, are ignored.
    a = ADDR_W'($urandom);
    d = DATA_W'($urandom);
    unlock();
    wr(15'h0555, 16'h00A0);
    wr(a, d);
    wr(15'h0555, 16'h00F0);
    busy_watch(PROG_CYCLES - 2, "busy_ignore");
    model[a] = model[a] & d;
    read_chk(a, "busy_ignore_rd");

    // we_n held low 5 cycles is a single write.
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    cyc();
    addr = 15'h0555; tb_dq = 16'h00AA; tb_drv = 1'b1; ce_n = 1'b0; we_n = 1'b0;
    repeat (5) cyc();
    ce_n = 1'b1; we_n = 1'b1; tb_drv = 1'b0;
    a = ADDR_W'($urandom);
    d = DATA_W'($urandom);
    wr(15'h02AA, 16'h0055);
    wr(15'h0555, 16'h00A0);
    wr(a, d);
    busy_watch(PROG_CYCLES, "long_we");
    model[a] = model[a] & d;
    read_chk(a, "long_we_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_cmd_model.md
FLASH_CMD_MODEL -- requirements
Module: flash_cmd_model

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data bus width (>= 8).
REQ-002 SHALL have parameter ADDR_W, default 15, word address width (>= 11).
REQ-003 SHALL have parameter RD_LAT, default 2, read latency in clk cycles (>= 1).
REQ-004 SHALL have parameter PROG_CYCLES, default 4, program busy time in clk cycles (>= 1).
REQ-005 SHALL have parameter ERASE_CYCLES, default 64, erase busy time in clk cycles (>= 1).
REQ-006 SHALL have parameter SECTOR_W, default 10, log2 of words per sector (< ADDR_W).
REQ-007 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port flash_address, input, ADDR_W, word address.
REQ-010 SHALL have ports flash_ce_n, flash_oe_n and flash_we_n, input, 1 each, active-low chip, output and write enables.
REQ-011 SHALL have port flash_data, inout, DATA_W, bidirectional data bus.
REQ-012 SHALL have port flash_ready, output, 1, 1 = ready, 0 = program/erase in progress.

Function
REQ-013 SHALL hold a 2^ADDR_W x DATA_W storage array; rst_n SHALL NOT alter its contents.
REQ-014 SHALL drive flash_data only when ce_n=0, oe_n=0, we_n=1, else high-Z; simultaneous oe_n=0/we_n=0 SHALL be treated as a write with the bus undriven.
REQ-015 SHALL, when ready, drive the array word at the address sampled RD_LAT cycles earlier (registered address pipeline).
REQ-016 SHALL, when busy, drive status instead of array data: DQ7=0, DQ6 toggling each clk cycle the output is enabled, all other bits 0.
REQ-017 SHALL register a write exactly once per we_n pulse: on the first clk edge where ce_n=0 and we_n=0 following a cycle with we_n=1 or ce_n=1; address and low 8 data bits captured then.
REQ-018 SHALL implement command FSM states READ, UNLK1, UNLK2, PROG_SETUP, ERASE_SETUP, BUSY_PROG, BUSY_ERASE.
REQ-019 SHALL transition READ->UNLK1 on write addr[10:0]=0x555, data=0xAA; UNLK1->UNLK2 on addr[10:0]=0x2AA, data=0x55.
REQ-020 SHALL transition UNLK2->PROG_SETUP on addr[10:0]=0x555, data=0xA0, and UNLK2->ERASE_SETUP on addr[10:0]=0x555, data=0x80.
REQ-021 SHALL, in PROG_SETUP, capture the next write's address and full data, load busy counter with PROG_CYCLES, enter BUSY_PROG.
REQ-022 SHALL, in ERASE_SETUP, on data 0x30 latch the sector (addr[ADDR_W-1:SECTOR_W]) and enter BUSY_ERASE; on data 0x10 flag chip erase and enter BUSY_ERASE; counter loaded with ERASE_CYCLES.
REQ-023 SHALL return to READ on any non-matching write in READ/UNLK1/UNLK2/ERASE_SETUP, including 0xF0 (reset command).
REQ-024 SHALL ignore all writes, including 0xF0, in BUSY_PROG and BUSY_ERASE.
REQ-025 SHALL apply program on the cycle the counter reaches 0 as array[a] = array[a] AND data (bits only 1->0), then enter READ.
REQ-026 SHALL apply erase on counter completion by setting every word of the latched sector (or whole array for chip erase) to all ones, then enter READ.
REQ-027 SHALL drive flash_ready=0 exactly in BUSY_PROG/BUSY_ERASE, i.e. for PROG_CYCLES or ERASE_CYCLES cycles starting the cycle after the final command write.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously force FSM to READ, busy counter 0, flash_ready=1, DQ6 toggle 0, read pipeline 0, write-edge detector to "we_n high".
REQ-029 SHALL abort any program/erase on reset mid-operation with the array unchanged (update applied only at completion).

Configuration
REQ-030 SHALL compile erase support only when FLASH_MODEL_ERASE_EN is defined; without it, ERASE_SETUP and BUSY_ERASE SHALL be absent and UNLK2 with data 0x80 SHALL return to READ.

Verification
REQ-031 Reset then read addr 0x0100 preloaded 0x1234 -> flash_data=0x1234 RD_LAT=2 cycles after address applied; high-Z when oe_n=1.
REQ-032 Writes 555/AA, 2AA/55, 555/A0, 0x0100/0x0F0F on word 0xFFFF -> flash_ready=0 for 4 cycles, DQ6 toggles on reads, then read 0x0100 = 0x0F0F.
REQ-033 Program 0x00F0 over existing 0x0F0F -> result 0x0000 (AND semantics).
REQ-034 Unlock + 555/80 + 0x0400/30 -> ready low 64 cycles; words 0x0400-0x07FF read 0xFFFF, 0x0100 unchanged; without FLASH_MODEL_ERASE_EN, ready stays 1 and FSM returns to READ.
REQ-035 Unlock + program started, rst_n pulsed at busy cycle 2 -> flash_ready=1 immediately, target word keeps old value, FSM in READ.
REQ-036 555/AA then 2AA/F0 -> returns to READ; writes during busy (incl. F0) ignored; we_n held low 5 cycles counts as one write.
